funnel_dat_gearbox: RTL
=======================

Name: funnel_dat_gearbox

Overview:
- Parametrised successor to the fixed 4-lane combinational funnels.
- Accepts one wide word of N_IN lanes per handshake and emits it as a sequence of narrower beats of N_OUT lanes each, over a req/ack handshake.
- Per-word configuration selects lane order and beat count (truncation).
- Sits between a wide producer (e.g. vector unit result bus) and a narrower consumer; registered output with back-to-back word streaming.

Parameters:
LANE_W, 128, width of one lane in bits
N_IN, 4, lanes per input word
N_OUT, 1, lanes per output beat; N_IN must be an integer multiple of N_OUT
BEATS, N_IN/N_OUT (derived localparam), maximum beats per word
CNT_W, clog2(BEATS)+1 (derived), beat counter width

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
t_0_dat  input  N_IN*LANE_W  input word; lane j = bits [j*LANE_W +: LANE_W]
t_0_req  input  1  input word valid
t_0_ack  output  1  input word accepted this cycle when t_0_req&t_0_ack
t_cfg_dat  input  8  per-word config, sampled with t_0_dat on accept
i_0_dat  output  N_OUT*LANE_W  current output beat
i_0_req  output  1  output beat valid
i_0_ack  input  1  consumer accepts beat when i_0_req&i_0_ack
i_0_last  output  1  high on final beat of a word
mode  output  8  t_cfg_dat latched for the word currently being emitted

Behaviour:
- Config fields: cfg[0] = REV (reverse group order); cfg[7:4] = LEN_M1. Effective length LEN = min(LEN_M1+1, BEATS). cfg[3:1] are reserved: stored in mode, otherwise ignored.
- Group g = lanes [g*N_OUT .. g*N_OUT+N_OUT-1].
- Beat k (0..LEN-1) carries group k when REV=0 and group BEATS-1-k when REV=1. Groups not reached are dropped silently.
- States:
  - IDLE: no word held. i_0_req=0; t_0_ack=1.
  - SEND: word held. i_0_req=1; t_0_ack = i_0_ack & i_0_last (combinational path from i_0_ack).
- Transitions:
  - IDLE, t_0_req=1: latch word and cfg, beat=0, present beat 0 on next cycle, go to SEND. Latency is 1 cycle from accept to first i_0_req.
  - SEND, i_0_ack=1 and not last: beat+1, load next group.
  - SEND, i_0_ack=1 and last, t_0_req=1: accept the new word in the same cycle, restart at beat 0, stay in SEND. No bubble.
  - SEND, i_0_ack=1 and last, t_0_req=0: go to IDLE.
- i_0_last = (beat == LEN-1). For LEN=1 every beat is last.
- Stability: while i_0_req & !i_0_ack, i_0_dat, i_0_last and mode hold their values.
- i_0_dat, i_0_last and mode are registered. Zero combinational path from t_0_dat to i_0_dat.
- Reset (any cycle, including mid-word): state=IDLE, beat=0, i_0_req=0, i_0_last=0, i_0_dat=0, mode=0. The held word is discarded with no partial flush. The t_0_req/ack handshake in a reset cycle is ignored (t_0_ack=0 during reset).
- In IDLE, i_0_dat and i_0_last keep their last values. Consumers must qualify on i_0_req.
- Elaboration error if N_IN % N_OUT != 0 or N_OUT > N_IN. N_OUT==N_IN gives BEATS=1, a registered pass-through with handshake.

Test Plan:
Defaults throughout; lanes A0..A3 = 128'hA0..128'hA3, B0..B3 = 128'hB0..128'hB3.
- Basic: word A, cfg=8'h30, i_0_ack=1 -> beats A0,A1,A2,A3 on 4 consecutive cycles starting 1 cycle after accept; i_0_last only on A3; mode=8'h30.
- Reverse+truncate: cfg=8'h11 -> 2 beats A3,A2; last on A2; then IDLE; mode=8'h11.
- Back-to-back: word A (cfg 8'h30) then B (cfg 8'h00) held on t_0_req -> B accepted in the A3 cycle; stream A0..A3,B0 with no gap; last on A3 and on B0; mode switches to 8'h00 on B0.
- Backpressure: cfg=8'h30, i_0_ack low for 3 cycles at beat A1 -> A1/last/mode stable; t_0_ack=0 throughout; resumes A2,A3.
- Clamp: cfg=8'hF0 -> exactly 4 beats, last on A3.
- Reset mid-word: assert reset during beat A1 -> next cycle i_0_req=0, i_0_dat=0, mode=0. After release, a new word B cfg 8'h30 streams from B0.

Source files
------------

// File: rtl/funnel_dat_gearbox.sv
// rtl/funnel_dat_gearbox.sv - wide-to-narrow lane gearbox with per-word order/length config
module funnel_dat_gearbox #(
    parameter int LANE_W = 128,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN*LANE_W-1:0]  t_0_dat,
    input  logic                    t_0_req,
    output logic                    t_0_ack,
    input  logic [7:0]              t_cfg_dat,
    output logic [N_OUT*LANE_W-1:0] i_0_dat,
    output logic                    i_0_req,
    input  logic                    i_0_ack,
    output logic                    i_0_last,
    output logic [7:0]              mode
);

    localparam int BEATS = N_IN / N_OUT;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int GRP_W = N_OUT * LANE_W;

    if ((N_OUT > N_IN) || ((N_IN % N_OUT) != 0)) begin : g_bad_lanes
        $error("funnel_dat_gearbox: N_IN must be an integer multiple of N_OUT");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state, state_nxt;
    logic [N_IN*LANE_W-1:0]  word;
    logic [CNT_W-1:0]        beat;
    logic [CNT_W-1:0]        beat_nxt;
    logic                    accept;
    logic                    advance;

    // Index of the final beat: LEN_M1 clamped to the number of groups in a word.
    function automatic logic [CNT_W-1:0] last_of(input logic [7:0] cfg);
        if (int'(cfg[7:4]) >= BEATS - 1)
            return CNT_W'(BEATS - 1);
        else
            return CNT_W'(cfg[7:4]);
    endfunction

    function automatic logic [GRP_W-1:0] group_of(input logic [N_IN*LANE_W-1:0] w,
                                                  input logic [CNT_W-1:0]       k,
                                                  input logic                   rev);
        int g;
        g = rev ? (BEATS - 1 - int'(k)) : int'(k);
        return w[g*GRP_W +: GRP_W];
    endfunction

    assign accept   = t_0_req & t_0_ack;
    assign advance  = (state == SEND) & i_0_ack & ~i_0_last;
    assign beat_nxt = beat + 1'b1;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SEND;
            SEND: if (i_0_ack && i_0_last) state_nxt = accept ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The accept path reaches back through i_0_ack so a new word can replace the last beat without a bubble.
    always_comb begin
        i_0_req = (state == SEND);
        t_0_ack = ~reset & ((state == IDLE) | (i_0_ack & i_0_last));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word     <= '0;
            beat     <= '0;
            i_0_dat  <= '0;
            i_0_last <= 1'b0;
            mode     <= '0;
        end else if (accept) begin
            word     <= t_0_dat;
            mode     <= t_cfg_dat;
            beat     <= '0;
            i_0_dat  <= group_of(t_0_dat, '0, t_cfg_dat[0]);
            i_0_last <= (last_of(t_cfg_dat) == '0);
        end else if (advance) begin
            beat     <= beat_nxt;
            i_0_dat  <= group_of(word, beat_nxt, mode[0]);
            i_0_last <= (beat_nxt == last_of(mode));
        end
    end

endmodule
